uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver with runtime-selectable frame format, 16x oversampling with majority-vote sampling, per-entry error tagging, break detection and an integrated receive FIFO. It is the next generation of the codebase's fixed 8-bit, odd-parity-free receiver. It sits between the pad-side `rx` line and a register/bus front end that drains bytes with `pop`. The whole block runs on a single clock: the baud tick is generated internally from `div`, with no separate `fclk`.

## Interface
- `DW`, 8: maximum data bits per frame (5..16).
- `CMSB`, 12: MSB of the oversample divider.
- `DEPTH`, 8: FIFO entries (power of 2, ≥2).
- `AW`, 3: log2(DEPTH).

Ports:
- `clk`  in  1  block clock.
- `rstn`  in  1  asynchronous active-low reset.
- `en`  in  1  receiver enable; low aborts any frame in progress.
- `div`  in  CMSB+1  oversample tick every `div`+1 clk cycles (16 ticks per bit).
- `nbits`  in  4  data bits per frame; 0 or >`DW` means `DW`.
- `pmode`  in  2  00 none, 01 even, 10 odd, 11 none.
- `stop2`  in  1  expect two stop bits.
- `rx`  in  1  serial input, asynchronous.
- `pop`  in  1  remove head entry (ignored when empty).
- `clear`  in  1  flush FIFO, clear `ovr`, abort frame.
- `rvalid`  out  1  FIFO not empty.
- `rdata`  out  DW  head data, LSB = first received bit, unused MSBs 0; 0 when empty.
- `rperr`, `rferr`, `rbrk`  out  1 each  head-entry parity error, framing error, break; 0 when empty.
- `level`  out  AW+1  entries held.
- `full`  out  1  `level`==`DEPTH`.
- `ovr`  out  1  sticky overrun.

## Operation
- `rx` passes through a 2-FF synchroniser, reset value 1. All sampling uses the synchronised value.
- Tick counter: counts 0..`div`, and `tick` pulses when it wraps. It is free-running while `en` is high and held at 0 otherwise.
- FSM states: IDLE, START, DATA, PAR, STOP, WAITHI.
- IDLE:
  - A synchronised falling edge (1→0) moves to START and resets the 4-bit sample counter `sc` to 0.
  - `sc` advances on each tick; a bit ends when `sc` wraps 15→0.
- Bit value: majority of the samples taken at `sc`=7, 8, 9. The decision is made on the tick where `sc`=9.
- START: if the majority is 1, the edge was a glitch → IDLE, no write. Otherwise move to DATA at the end of the bit.
- DATA: shift in the effective `nbits` bits, LSB first. Then go to PAR if `pmode` ∈ {01,10}, else STOP.
- PAR:
  - Even mode: `rperr`=1 when XOR(data, parity bit) is not 0.
  - Odd mode: `rperr`=1 when that XOR is not 1.
- STOP:
  - `rferr`=1 if any stop bit majority is 0.
  - With `stop2`, the second stop bit is also checked.
  - The FIFO write happens at the `sc`=9 decision of the last stop bit. The FSM does not wait for the bit to end, which allows resynchronisation.
- Break:
  - Condition: data all 0, parity bit (if present) 0, and first stop bit 0.
  - The entry is written with `rbrk`=1 and `rferr`=1, even when `stop2` is set.
  - The FSM then goes to WAITHI, which returns to IDLE only once the synchronised `rx`=1.
- Any other framing error returns to IDLE.
- `nbits`, `pmode`, `stop2` and `div` are sampled in IDLE only. Changes mid-frame take effect on the next frame.
- FIFO:
  - Write when full: the frame is dropped, `ovr` is set, and the head is unchanged.
  - Write and `pop` in the same cycle while full: both take effect, no overrun.
  - Write and `pop` in the same cycle while empty: the write takes effect and the `pop` is ignored.
  - Pointers wrap modulo `DEPTH`.
- `clear` takes priority over a same-cycle write and `pop`. After `clear`: `level`=0, `ovr`=0, FSM=IDLE.
- `en`=0: FSM→IDLE, sample/tick counters cleared, FIFO contents and `ovr` retained, `pop` still honoured.

## Timing
- Reset values: `rvalid`=0, `rdata`=0, `rperr`=`rferr`=`rbrk`=0, `level`=0, `full`=0, `ovr`=0, FSM=IDLE, synchroniser=11.
- `rvalid`, `level` and the head fields update 1 clk after the write cycle.
- `pop` updates the head on the next clk.
- Latency from the `rx` falling edge to the START entry: 2–3 clk (synchroniser + edge detect).
- Reset asserted mid-frame: everything returns to reset values immediately, and the partial frame is lost.
- All outputs are registered.

## Structure
- Shared package `uart_pkg`:
  - `pmode` encodings PM_NONE/PM_EVEN/PM_ODD.
  - FSM state encodings.
  - Sample-point constants (7/8/9) and OSR=16.
- Sub-module `uart_fifo`: synchronous FIFO with width `DW`+3 (data, perr, ferr, brk) and depth `DEPTH`. It owns push/pop/clear, `level`, `full` and overrun detection. The parent module holds the synchroniser, divider and FSM.

## Test plan
All scenarios use `div`=4, i.e. 80 clk per bit.
- 8N1, send 0xA5, no pop → `rvalid`=1 1 clk after the stop-bit `sc`=9 tick; `rdata`=0xA5, `rperr`=`rferr`=`rbrk`=0, `level`=1.
- `nbits`=7, `pmode`=01, `stop2`=1, send 0x41 with parity bit 1 → `rdata`=0x41, `rperr`=1. Repeat with parity bit 0 → `rperr`=0.
- `rx` low for 3 ticks, then high → no entry written, FSM back in IDLE, `level`=0.
- `DEPTH`=8, send 9 frames 0x00..0x08 without pop → `level`=8, `full`=1, `ovr`=1, `rdata`=0x00. Then `clear` → `level`=0, `ovr`=0, `rvalid`=0.
- Hold `rx` low for 20 bit times, release, then send 0x55 → exactly two entries: first {0x00, `rferr`=1, `rbrk`=1}, second {0x55, no errors}.
- Drop `en` at mid-data of a frame, then raise it and send 0x3C → only 0x3C appears. Repeat with `rstn` pulsed mid-frame → all outputs at reset values.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, FSM states,
// oversampling constants and the sample-vote helper.
package uart_pkg;

    localparam logic [1:0] PM_NONE = 2'b00;
    localparam logic [1:0] PM_EVEN = 2'b01;
    localparam logic [1:0] PM_ODD  = 2'b10;

    localparam int         OSR     = 16;
    localparam logic [3:0] SMP_A   = 4'd7;
    localparam logic [3:0] SMP_B   = 4'd8;
    localparam logic [3:0] SMP_C   = 4'd9;
    localparam logic [3:0] SC_LAST = 4'(OSR - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_WAITHI
    } state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Receive FIFO holding {brk, ferr, perr, data} entries with a registered head
// view, occupancy, full flag and sticky overrun.
module uart_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  head_o,
    output logic          valid_o,
    output logic [AW:0]   level_o,
    output logic          full_o,
    output logic          ovr_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [AW:0]   level_q, level_d;
    logic [W-1:0]  head_q, head_d;
    logic          valid_q, valid_d, full_q, full_d, ovr_q, ovr_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push = push_i && (!full_q || pop_i) && !clr_i;
        do_pop  = pop_i && (level_q != '0) && !clr_i;
        rptr_d  = rptr_q + AW'(do_pop);
        wptr_d  = wptr_q + AW'(do_push);
        level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        ovr_d   = ovr_q | (push_i && full_q && !pop_i);
        if (clr_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            level_d = '0;
            ovr_d   = 1'b0;
        end
        // The new head may be the very entry being written this cycle.
        if (level_d == '0)
            head_d = '0;
        else if (do_push && (rptr_d == wptr_q))
            head_d = wdata_i;
        else
            head_d = mem_q[rptr_d];
        valid_d = (level_d != '0);
        full_d  = (level_d == (AW+1)'(DEPTH));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            level_q <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            level_q <= level_d;
            head_q  <= head_d;
            valid_q <= valid_d;
            full_q  <= full_d;
            ovr_q   <= ovr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    assign head_o  = head_q;
    assign valid_o = valid_q;
    assign level_o = level_q;
    assign full_o  = full_q;
    assign ovr_o   = ovr_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: synchroniser, oversample divider and frame FSM with
// majority-vote sampling, break detection and an error-tagged receive FIFO.
module uart_rx_fifo import uart_pkg::*; #(
    parameter int DW    = 8,
    parameter int CMSB  = 12,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic [CMSB:0] div,
    input  logic [3:0]    nbits,
    input  logic [1:0]    pmode,
    input  logic          stop2,
    input  logic          rx,
    input  logic          pop,
    input  logic          clear,
    output logic          rvalid,
    output logic [DW-1:0] rdata,
    output logic          rperr,
    output logic          rferr,
    output logic          rbrk,
    output logic [AW:0]   level,
    output logic          full,
    output logic          ovr
);

    logic [1:0]    sync_q;
    logic          rxp_q;
    logic [CMSB:0] tcnt_q, tcnt_d, div_q, div_d;
    logic [4:0]    nb_q, nb_d;
    logic [1:0]    pm_q, pm_d;
    logic          st2_q, st2_d;
    state_e        state_q, state_d;
    logic [3:0]    sc_q, sc_d, bcnt_q, bcnt_d;
    logic          stp_q, stp_d;
    logic [1:0]    smp_q, smp_d;
    logic [DW-1:0] data_q, data_d;
    logic          par_q, par_d, perr_q, perr_d, ferr_q, ferr_d;
    logic          rx_s, fall, tick, wrap, decide, bitv, has_par;
    logic          push, push_ferr, push_brk;
    logic [DW+2:0] head;

    assign rx_s    = sync_q[1];
    assign fall    = rxp_q & ~rx_s;
    assign tick    = en && (tcnt_q >= div_q);
    assign wrap    = tick && (sc_q == SC_LAST);
    assign decide  = tick && (sc_q == SMP_C);
    assign bitv    = maj3(smp_q[1], smp_q[0], rx_s);
    assign has_par = (pm_q == PM_EVEN) || (pm_q == PM_ODD);

    always_comb begin
        tcnt_d = (!en || clear || tick) ? '0 : tcnt_q + (CMSB+1)'(1);
        div_d  = div_q;
        nb_d   = nb_q;
        pm_d   = pm_q;
        st2_d  = st2_q;
        // Frame format is frozen for the duration of a frame.
        if (state_q == S_IDLE) begin
            div_d = div;
            nb_d  = (nbits == 4'd0 || int'(nbits) > DW) ? 5'(DW) : {1'b0, nbits};
            pm_d  = pmode;
            st2_d = stop2;
        end
    end

    always_comb begin
        state_d   = state_q;
        sc_d      = tick ? sc_q + 4'd1 : sc_q;
        bcnt_d    = bcnt_q;
        stp_d     = stp_q;
        smp_d     = smp_q;
        data_d    = data_q;
        par_d     = par_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        push      = 1'b0;
        push_ferr = 1'b0;
        push_brk  = 1'b0;
        if (tick && sc_q == SMP_A) smp_d[1] = rx_s;
        if (tick && sc_q == SMP_B) smp_d[0] = rx_s;
        unique case (state_q)
            S_IDLE: if (fall) begin
                state_d = S_START;
                sc_d    = '0;
                data_d  = '0;
                par_d   = 1'b0;
                perr_d  = 1'b0;
                ferr_d  = 1'b0;
            end
            S_START: begin
                if (decide && bitv) state_d = S_IDLE;
                else if (wrap) begin
                    state_d = S_DATA;
                    bcnt_d  = '0;
                end
            end
            S_DATA: begin
                if (decide)
                    for (int i = 0; i < DW; i++)
                        if (bcnt_q == 4'(i)) data_d[i] = bitv;
                if (wrap) begin
                    if ({1'b0, bcnt_q} == nb_q - 5'd1) begin
                        state_d = has_par ? S_PAR : S_STOP;
                        stp_d   = 1'b0;
                    end else begin
                        bcnt_d = bcnt_q + 4'd1;
                    end
                end
            end
            S_PAR: begin
                if (decide) begin
                    par_d  = bitv;
                    perr_d = ((^data_q) ^ bitv) != (pm_q == PM_ODD);
                end
                if (wrap) begin
                    state_d = S_STOP;
                    stp_d   = 1'b0;
                end
            end
            S_STOP: begin
                // Entries are written mid stop bit so the next start edge is not missed.
                if (decide) begin
                    if (!stp_q && data_q == '0 && !par_q && !bitv) begin
                        push      = 1'b1;
                        push_ferr = 1'b1;
                        push_brk  = 1'b1;
                        state_d   = S_WAITHI;
                    end else if (st2_q && !stp_q) begin
                        ferr_d = ~bitv;
                    end else begin
                        push      = 1'b1;
                        push_ferr = ferr_q | ~bitv;
                        state_d   = S_IDLE;
                    end
                end
                if (wrap) stp_d = 1'b1;
            end
            S_WAITHI: if (rx_s) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (!en || clear) begin
            state_d = S_IDLE;
            sc_d    = '0;
            push    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q  <= 2'b11;
            rxp_q   <= 1'b1;
            tcnt_q  <= '0;
            div_q   <= '0;
            nb_q    <= 5'(DW);
            pm_q    <= PM_NONE;
            st2_q   <= 1'b0;
            state_q <= S_IDLE;
            sc_q    <= '0;
            bcnt_q  <= '0;
            stp_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            rxp_q   <= rx_s;
            tcnt_q  <= tcnt_d;
            div_q   <= div_d;
            nb_q    <= nb_d;
            pm_q    <= pm_d;
            st2_q   <= st2_d;
            state_q <= state_d;
            sc_q    <= sc_d;
            bcnt_q  <= bcnt_d;
            stp_q   <= stp_d;
        end
    end

    always_ff @(posedge clk) begin
        smp_q  <= smp_d;
        data_q <= data_d;
        par_q  <= par_d;
        perr_q <= perr_d;
        ferr_q <= ferr_d;
    end

    uart_fifo #(.W(DW + 3), .DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .clr_i   (clear),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({push_brk, push_ferr, perr_q, data_q}),
        .head_o  (head),
        .valid_o (rvalid),
        .level_o (level),
        .full_o  (full),
        .ovr_o   (ovr)
    );

    assign rdata = head[DW-1:0];
    assign rperr = head[DW];
    assign rferr = head[DW+1];
    assign rbrk  = head[DW+2];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed frames at div=4 (80 clk per bit),
// expected entries queued by the stimulus and drained/compared by a monitor.
module tb_uart_rx_fifo;

    localparam int DW = 8, CMSB = 12, DEPTH = 8, AW = 3, BT = 80;

    logic          clk = 1'b0;
    logic          rstn, en, stop2, rx, clear;
    logic          pop = 1'b0;
    logic [CMSB:0] div;
    logic [3:0]    nbits;
    logic [1:0]    pmode;
    logic          rvalid, rperr, rferr, rbrk, full, ovr;
    logic [DW-1:0] rdata;
    logic [AW:0]   level;

    int            n_cmp = 0, n_bad = 0;
    logic          auto_pop = 1'b0;
    logic [DW+2:0] exp_q[$];
    logic [DW+2:0] mon_exp, mon_got;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DW(DW), .CMSB(CMSB), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rstn(rstn), .en(en), .div(div), .nbits(nbits), .pmode(pmode),
        .stop2(stop2), .rx(rx), .pop(pop), .clear(clear), .rvalid(rvalid),
        .rdata(rdata), .rperr(rperr), .rferr(rferr), .rbrk(rbrk), .level(level),
        .full(full), .ovr(ovr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: whenever an entry is visible and draining is enabled, compare and pop it.
    always @(negedge clk) begin
        pop = 1'b0;
        if (auto_pop && rvalid) begin
            mon_got = {rbrk, rferr, rperr, rdata};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_entry: got %0h expected none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_bad++;
                    $display("FAIL entry: got %0h expected %0h", mon_got, mon_exp);
                end
            end
            pop = 1'b1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        cyc(BT);
    endtask

    task automatic frame(input logic [15:0] d, input int n, input int par, input int nstop);
        send_bit(1'b0);
        for (int i = 0; i < n; i++) send_bit(d[i]);
        if (par >= 0) send_bit(par[0]);
        for (int i = 0; i < nstop; i++) send_bit(1'b1);
    endtask

    task automatic expect_entry(input logic [7:0] d, input logic pe, input logic fe, input logic bk);
        exp_q.push_back({bk, fe, pe, d});
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 4000 && (exp_q.size() != 0 || rvalid); i++) cyc(1);
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_rvalid"}, rvalid, 0);
        check({name, "_rdata"}, rdata, 0);
        check({name, "_flags"}, {rperr, rferr, rbrk}, 0);
        check({name, "_level"}, level, 0);
        check({name, "_full"}, full, 0);
        check({name, "_ovr"}, ovr, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0; en = 1'b1; rx = 1'b1; clear = 1'b0;
        div = 13'd4; nbits = 4'd8; pmode = 2'b00; stop2 = 1'b0;
        cyc(3);
        check_reset_outputs("reset");
        rstn = 1'b1;
        cyc(BT);

        // 8N1 0xA5: write lands 1 clk after the stop-bit sc=9 tick (~770 clk after the edge).
        expect_entry(8'hA5, 1'b0, 1'b0, 1'b0);
        fork
            frame(16'hA5, 8, -1, 1);
            begin
                cyc(760);
                check("a5_early_rvalid", rvalid, 0);
                cyc(20);
                check("a5_rvalid", rvalid, 1);
            end
        join
        check("a5_rdata", rdata, 8'hA5);
        check("a5_flags", {rperr, rferr, rbrk}, 0);
        check("a5_level", level, 1);
        auto_pop = 1'b1;
        wait_drain("a5_drain");

        // 7E2 / 7O2 parity cases.
        nbits = 4'd7; pmode = 2'b01; stop2 = 1'b1;
        cyc(2);
        expect_entry(8'h41, 1'b1, 1'b0, 1'b0);
        frame(16'h41, 7, 1, 2);
        expect_entry(8'h41, 1'b0, 1'b0, 1'b0);
        frame(16'h41, 7, 0, 2);
        pmode = 2'b10;
        cyc(BT);
        expect_entry(8'h41, 1'b0, 1'b0, 1'b0);
        frame(16'h41, 7, 1, 2);
        expect_entry(8'h41, 1'b1, 1'b0, 1'b0);
        frame(16'h41, 7, 0, 2);
        wait_drain("parity_drain");
        nbits = 4'd8; pmode = 2'b00; stop2 = 1'b0;
        cyc(2);

        // Start-bit glitch of 3 ticks: rejected, then a clean frame follows.
        auto_pop = 1'b0;
        rx = 1'b0;
        cyc(15);
        rx = 1'b1;
        cyc(3 * BT);
        check("glitch_level", level, 0);
        check("glitch_rvalid", rvalid, 0);
        auto_pop = 1'b1;
        expect_entry(8'h12, 1'b0, 1'b0, 1'b0);
        frame(16'h12, 8, -1, 1);
        wait_drain("glitch_next_drain");

        // Nine frames into an 8-deep FIFO without draining.
        auto_pop = 1'b0;
        for (int i = 0; i < 9; i++) frame(16'(i), 8, -1, 1);
        cyc(BT);
        check("ovf_level", level, 8);
        check("ovf_full", full, 1);
        check("ovf_ovr", ovr, 1);
        check("ovf_rdata", rdata, 8'h00);
        check("ovf_rvalid", rvalid, 1);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        check("clr_level", level, 0);
        check("clr_ovr", ovr, 0);
        check("clr_rvalid", rvalid, 0);
        check("clr_full", full, 0);

        // Break: 20 bit times low, then a normal 0x55.
        auto_pop = 1'b1;
        expect_entry(8'h00, 1'b0, 1'b1, 1'b1);
        expect_entry(8'h55, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        cyc(20 * BT);
        rx = 1'b1;
        cyc(2 * BT);
        frame(16'h55, 8, -1, 1);
        wait_drain("break_drain");

        // Enable dropped mid-data: partial frame discarded.
        expect_entry(8'h3C, 1'b0, 1'b0, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        en = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        send_bit(1'b1);
        en = 1'b1;
        cyc(BT);
        frame(16'h3C, 8, -1, 1);
        wait_drain("en_drain");

        // Reset mid-frame with one entry held.
        auto_pop = 1'b0;
        frame(16'h77, 8, -1, 1);
        cyc(BT);
        check("prerst_level", level, 1);
        check("prerst_rdata", rdata, 8'h77);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rstn = 1'b0;
        cyc(2);
        check_reset_outputs("rst_mid");
        for (int i = 0; i < 6; i++) send_bit(1'b0);
        send_bit(1'b1);
        rstn = 1'b1;
        cyc(2 * BT);
        check("postrst_level", level, 0);
        check("postrst_rvalid", rvalid, 0);

        check("end_queue", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
